// File: rtl/disp_pkg.sv
// Shared constants and types for the display scan controller.
// Segment codes are g..a, active-high.
package disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111100;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1100111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GUARD
  } scan_st_t;

  localparam logic [2:0] SEC_LO = 3'd0;
  localparam logic [2:0] SEC_HI = 3'd1;
  localparam logic [2:0] MIN_LO = 3'd2;
  localparam logic [2:0] MIN_HI = 3'd3;
  localparam logic [2:0] HR_LO  = 3'd4;
  localparam logic [2:0] HR_HI  = 3'd5;

  // Map a digit index to its blink_sel field bit.
  function automatic logic [1:0] field_of(
    input logic [2:0] idx
  );
    logic [1:0] f;
    f = 2'd0;
    unique case (1'b1)
      (idx == SEC_LO || idx == SEC_HI): f = 2'd0;
      (idx == MIN_LO || idx == MIN_HI): f = 2'd1;
      default:                          f = 2'd2;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Time-word and display-pin bundle for disp_scan_ctrl.
// master = time source / pin observer, slave = controller.
interface disp_scan_ctrl_if;

  logic [23:0] time_in;
  logic        time_vld;
  logic        time_ack;
  logic [2:0]  blink_sel;
  logic        disp_en;
  logic [6:0]  seg;
  logic [5:0]  dig_sel;
  logic        frame_done;

  modport master (
    output time_in, time_vld,
    output blink_sel, disp_en,
    input  time_ack, seg,
    input  dig_sel, frame_done
  );

  modport slave (
    input  time_in, time_vld,
    input  blink_sel, disp_en,
    output time_ack, seg,
    output dig_sel, frame_done
  );

endinterface

// File: rtl/bcd_seg7_dec.sv
// Combinational BCD to 7-segment decoder (g..a).
// Non-BCD nibbles decode blank.
module bcd_seg7_dec
  import disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Table lookup, blank for 10..15
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Six-digit multiplexed 7-seg scan controller with guard gaps and blink.
// Optional DISP_LZB_EN: blank a zero hours-tens digit.
module disp_scan_ctrl #(
  parameter int CLK_DIV   = 50000,
  parameter int GUARD_CYC = 8,
  parameter int BLINK_DIV = 64
) (
  input  logic             clk,
  input  logic             rst,
  disp_scan_ctrl_if.slave  bus
);

  import disp_pkg::*;

  localparam int PW = $clog2(CLK_DIV);
  localparam int FW = $clog2(BLINK_DIV + 1);

  scan_st_t        r_state;
  logic [PW-1:0]   r_presc;
  logic [2:0]      r_idx;
  logic [23:0]     r_shadow;
  logic [FW-1:0]   r_frm;
  logic            r_phase;
  logic [6:0]      r_seg;
  logic [5:0]      r_dig;
  logic            r_ack;
  logic            r_fd;

  logic            w_show_end;
  logic            w_guard_end;
  logic            w_wrap;
  logic            w_load;
  logic [2:0]      w_nxt_idx;
  logic [23:0]     w_src;
  logic [3:0]      w_nib;
  logic [6:0]      w_dec;
  logic            w_blink;
  logic            w_lzb;
  logic [6:0]      w_seg_on;
  logic [5:0]      w_onehot;

  assign w_show_end  = (r_state == SHOW) &&
                       (r_presc == PW'(CLK_DIV - 1));
  assign w_guard_end = (r_state == GUARD) &&
                       (r_presc == PW'(GUARD_CYC - 1));
  assign w_wrap      = w_guard_end && (r_idx == HR_HI);
  assign w_load      = bus.time_vld &&
                       ((r_state == IDLE) ||
                        (w_wrap && bus.disp_en));

  // Digit about to be lit: next in GUARD, digit 0 from IDLE.
  assign w_nxt_idx = (r_state != GUARD) ? 3'd0 :
                     (r_idx == HR_HI)   ? 3'd0 :
                                          r_idx + 3'd1;

  // Decode from the word the shadow will hold after this edge.
  assign w_src = w_load ? bus.time_in : r_shadow;
  assign w_nib = w_src[{w_nxt_idx, 2'b00} +: 4];

  bcd_seg7_dec u_dec (
    .i_bcd (w_nib),
    .o_seg (w_dec)
  );

  assign w_blink = r_phase &&
                   bus.blink_sel[field_of(w_nxt_idx)];

`ifdef DISP_LZB_EN
  assign w_lzb = (w_nxt_idx == HR_HI) && (w_nib == 4'd0);
`else
  assign w_lzb = 1'b0;
`endif

  assign w_seg_on = (w_blink || w_lzb) ? SEG_BLANK : w_dec;
  assign w_onehot = 6'd1 << w_nxt_idx;

  // Scan FSM; outputs registered alongside the state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_presc  <= '0;
      r_idx    <= 3'd0;
      r_shadow <= '0;
      r_frm    <= '0;
      r_phase  <= 1'b0;
      r_seg    <= SEG_BLANK;
      r_dig    <= '0;
      r_ack    <= 1'b0;
      r_fd     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_fd  <= 1'b0;
      if (w_load) begin
        r_shadow <= bus.time_in;
        r_ack    <= 1'b1;
      end
      if (!bus.disp_en) begin
        r_state <= IDLE;
        r_idx   <= 3'd0;
        r_presc <= '0;
        r_seg   <= SEG_BLANK;
        r_dig   <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_state <= SHOW;
            r_idx   <= 3'd0;
            r_presc <= '0;
            r_dig   <= w_onehot;
            r_seg   <= w_seg_on;
          end
          SHOW: begin
            if (w_show_end) begin
              r_state <= GUARD;
              r_presc <= '0;
              r_dig   <= '0;
              r_seg   <= SEG_BLANK;
              if (r_idx == HR_HI) begin
                r_fd <= 1'b1;
                if (r_frm == FW'(BLINK_DIV - 1)) begin
                  r_frm   <= '0;
                  r_phase <= ~r_phase;
                end else begin
                  r_frm <= r_frm + 1'b1;
                end
              end
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
          GUARD: begin
            if (w_guard_end) begin
              r_state <= SHOW;
              r_idx   <= w_nxt_idx;
              r_presc <= '0;
              r_dig   <= w_onehot;
              r_seg   <= w_seg_on;
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dig_sel    = r_dig;
  assign bus.time_ack   = r_ack;
  assign bus.frame_done = r_fd;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl (CLK_DIV=4, GUARD_CYC=1, BLINK_DIV=2).
// Each digit slot: 4 lit cycles then 1 dark guard cycle.
module tb_disp_scan_ctrl;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S6 = 7'b1111100;
  localparam logic [6:0] SB = 7'b0000000;
`ifdef DISP_LZB_EN
  localparam logic [6:0] D5Z = 7'b0000000;
`else
  localparam logic [6:0] D5Z = 7'b0111111;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic fd_seen;

  always #5 clk = ~clk;

  disp_scan_ctrl_if bus ();

  disp_scan_ctrl #(
    .CLK_DIV   (4),
    .GUARD_CYC (1),
    .BLINK_DIV (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [23:0] obs,
    input logic [23:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic slot(
    input int         idx,
    input logic [6:0] sg,
    input logic       ack
  );
    logic [5:0] oh;
    oh = 6'd1 << idx;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("dig%0d_sel", idx), 24'(bus.dig_sel), 24'(oh));
      chk($sformatf("dig%0d_seg", idx), 24'(bus.seg), 24'(sg));
      chk($sformatf("dig%0d_ack", idx), 24'(bus.time_ack),
          24'((i == 0) ? ack : 1'b0));
      chk($sformatf("dig%0d_fd", idx), 24'(bus.frame_done), 24'd0);
      if (i == 0 && ack) bus.time_vld = 1'b0;
    end
    step();
    chk($sformatf("gap%0d_sel", idx), 24'(bus.dig_sel), 24'd0);
    chk($sformatf("gap%0d_seg", idx), 24'(bus.seg), 24'd0);
    chk($sformatf("gap%0d_ack", idx), 24'(bus.time_ack), 24'd0);
    chk($sformatf("gap%0d_fd", idx), 24'(bus.frame_done),
        24'(idx == 5));
  endtask

  initial begin
    rst           = 1'b1;
    bus.time_in   = 24'h0;
    bus.time_vld  = 1'b0;
    bus.blink_sel = 3'b000;
    bus.disp_en   = 1'b0;
    step();
    step();
    chk("rst_seg", 24'(bus.seg), 24'd0);
    chk("rst_dig", 24'(bus.dig_sel), 24'd0);
    chk("rst_ack", 24'(bus.time_ack), 24'd0);
    chk("rst_fd", 24'(bus.frame_done), 24'd0);

    // Frame 1: load from IDLE, scan 123456
    rst          = 1'b0;
    bus.time_in  = 24'h123456;
    bus.time_vld = 1'b1;
    bus.disp_en  = 1'b1;
    slot(0, S6, 1'b1);
    slot(1, S5, 1'b0);
    slot(2, S4, 1'b0);
    slot(3, S3, 1'b0);
    slot(4, S2, 1'b0);
    slot(5, S1, 1'b0);

    // Frame 2: new word offered mid-frame, held off
    slot(0, S6, 1'b0);
    slot(1, S5, 1'b0);
    bus.time_in  = 24'h000000;
    bus.time_vld = 1'b1;
    slot(2, S4, 1'b0);
    slot(3, S3, 1'b0);
    slot(4, S2, 1'b0);
    slot(5, S1, 1'b0);

    // Frame 3: loaded at wrap; phase=1 but no field selected
    slot(0, S0, 1'b1);
    slot(1, S0, 1'b0);
    slot(2, S0, 1'b0);
    slot(3, S0, 1'b0);
    slot(4, S0, 1'b0);
    slot(5, D5Z, 1'b0);

    // Frame 4: minutes blink blanked (phase=1)
    bus.blink_sel = 3'b010;
    slot(0, S0, 1'b0);
    slot(1, S0, 1'b0);
    slot(2, SB, 1'b0);
    slot(3, SB, 1'b0);
    bus.time_in  = 24'h0F0000;
    bus.time_vld = 1'b1;
    slot(4, S0, 1'b0);
    slot(5, D5Z, 1'b0);

    // Frame 5: phase=0, invalid BCD in hr ones
    slot(0, S0, 1'b1);
    slot(1, S0, 1'b0);
    slot(2, S0, 1'b0);
    slot(3, S0, 1'b0);
    slot(4, SB, 1'b0);
    slot(5, D5Z, 1'b0);

    // Frame 6: disable during digit 3
    slot(0, S0, 1'b0);
    slot(1, S0, 1'b0);
    slot(2, S0, 1'b0);
    step();
    chk("d3_on", 24'(bus.dig_sel), 24'h000008);
    bus.disp_en = 1'b0;
    step();
    chk("dis_dig", 24'(bus.dig_sel), 24'd0);
    chk("dis_seg", 24'(bus.seg), 24'd0);
    chk("dis_fd", 24'(bus.frame_done), 24'd0);
    fd_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.frame_done || bus.dig_sel != 6'd0)
        fd_seen = 1'b1;
    end
    chk("idle_quiet", 24'(fd_seen), 24'd0);

    // Re-enable restarts at digit 0; reset in GUARD
    bus.disp_en = 1'b1;
    slot(0, S0, 1'b0);
    rst = 1'b1;
    step();
    chk("rstg_seg", 24'(bus.seg), 24'd0);
    chk("rstg_dig", 24'(bus.dig_sel), 24'd0);
    chk("rstg_ack", 24'(bus.time_ack), 24'd0);
    chk("rstg_fd", 24'(bus.frame_done), 24'd0);
    rst = 1'b0;
    slot(0, S0, 1'b0);
    slot(1, S0, 1'b0);
    slot(2, S0, 1'b0);
    slot(3, S0, 1'b0);
    slot(4, S0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
